// File: rtl/program_dumper.sv
// program_dumper: read-back engine for the unified program memory.
// On a start command it reads a contiguous, wrapping window of RAM through the
// shared request/grant port and streams each byte to the host over valid/ready.
// Read data is sampled on the READ_LATENCY-th consecutive granted cycle, so with
// READ_LATENCY=1 the RAM data must be valid in the same cycle the grant is given.
module program_dumper #(
   parameter int ADDR_WIDTH   = 5,
   parameter int DATA_WIDTH   = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clock_i,
   input  logic                  reset_ni,
   input  logic                  dump_start_i,
   input  logic [ADDR_WIDTH-1:0] dump_addr_i,
   input  logic [ADDR_WIDTH:0]   dump_count_i,
   input  logic                  mem_grant_i,
   input  logic [DATA_WIDTH-1:0] mem_read_data_i,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] dump_data_o,
   output logic                  dump_valid_o,
   input  logic                  dump_ready_i,
   output logic                  dump_last_o,
   output logic                  dump_busy_o,
   output logic                  dump_done_o
);

   localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_PRESENT, S_DONE} state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic [LW-1:0]         lat_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  req_q, valid_q, last_q, busy_q, done_q;
   logic                  lat_hit;

   // Next address wraps naturally at the top of RAM; remaining count after a handshake.
   always_comb begin
      addr_d  = addr_q + 1'b1;
      cnt_d   = cnt_q - 1'b1;
      lat_hit = (lat_q == LW'(READ_LATENCY - 1));
   end

   // Control FSM; every output is a register so the host and arbiter see clean levels.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         lat_q   <= '0;
         data_q  <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (dump_start_i) begin
                  addr_q <= dump_addr_i;
                  cnt_q  <= dump_count_i;
                  lat_q  <= '0;
                  busy_q <= 1'b1;
                  if (dump_count_i != '0) begin
                     state_q <= S_READ;
                     req_q   <= 1'b1;
                  end else begin
                     // empty window: no RAM traffic, just the completion pulse
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_READ: begin
               if (mem_grant_i) begin
                  if (lat_hit) begin
                     data_q  <= mem_read_data_i;
                     last_q  <= (cnt_q == (ADDR_WIDTH+1)'(1));
                     valid_q <= 1'b1;
                     req_q   <= 1'b0;
                     lat_q   <= '0;
                     state_q <= S_PRESENT;
                  end else begin
                     lat_q <= lat_q + 1'b1;
                  end
               end else begin
                  // losing the port invalidates any read in flight; start over
                  lat_q <= '0;
               end
            end
            S_PRESENT: begin
               if (dump_ready_i) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  addr_q  <= addr_d;
                  cnt_q   <= cnt_d;
                  if (cnt_d == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_READ;
                     req_q   <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_req_o    = req_q;
   assign mem_addr_o   = addr_q;
   assign dump_data_o  = data_q;
   assign dump_valid_o = valid_q;
   assign dump_last_o  = last_q;
   assign dump_busy_o  = busy_q;
   assign dump_done_o  = done_q;

endmodule
